counter_monitor: RTL

Receive-side companion to the parameterised up/down counter: samples the counter's N-bit output, predicts each next value, and reports whether the observed sequence is consistent. It sits beside or downstream of a counter instance. It gives benches and on-chip self-check logic a lock indication, per-event error pulses and a saturating error tally.

---
 rtl/counter_monitor.sv | 100 ++++++++++
 1 files changed

// File: rtl/counter_monitor.sv
// Tracks an up/down counter's output, predicts each next value, and flags lock, errors and an error tally.
// Latency: outputs are registered and update on the edge that samples cnt_in. Backpressure: none; valid gates sampling.
module counter_monitor #(
  parameter int N        = 3,
  parameter bit UP_DOWN  = 1'b1,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     cnt_in,
  input  logic             valid,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     expected
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [N-1:0]     ONE      = 1;
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state, state_nxt;
  logic [3:0]       match_cnt, match_nxt, match_inc;
  logic [N-1:0]     pred, expected_nxt;
  logic             hit, locked_nxt, error_nxt;
  logic [ERR_W-1:0] err_count_nxt;

  assign pred      = UP_DOWN ? (cnt_in + ONE) : (cnt_in - ONE);
  assign hit       = (cnt_in == expected);
  assign match_inc = match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (valid) begin
      case (state)
        SEARCH:  state_nxt = TRACK;
        TRACK:   if (hit && match_inc == LOCK_CNT) state_nxt = LOCKED;
        LOCKED:  if (!hit) state_nxt = TRACK;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    expected_nxt  = expected;
    match_nxt     = match_cnt;
    locked_nxt    = locked;
    error_nxt     = 1'b0;
    err_count_nxt = err_count;
    if (valid) begin
      // Every valid sample resyncs the prediction, match or not.
      expected_nxt = pred;
      case (state)
        SEARCH: match_nxt = 4'd0;
        TRACK: begin
          if (hit) begin
            match_nxt  = match_inc;
            locked_nxt = (match_inc == LOCK_CNT);
          end else begin
            match_nxt  = 4'd0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            error_nxt     = 1'b1;
            locked_nxt    = 1'b0;
            match_nxt     = 4'd0;
            err_count_nxt = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
          end
        end
        default: match_nxt = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      expected  <= '0;
      match_cnt <= 4'd0;
      locked    <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
    end else begin
      expected  <= expected_nxt;
      match_cnt <= match_nxt;
      locked    <= locked_nxt;
      error     <= error_nxt;
      err_count <= err_count_nxt;
    end
  end

endmodule
